// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch stage: default widths, the
// reset PC constant, the fetch FSM state encoding and an alignment helper.
// Optional feature macro used by the fetch stage: IF_MISALIGN_TRAP_EN.
// ---------------------------------------------------------------------------
package if_pkg;

    localparam int                 IF_AW_DEFAULT    = 32;
    localparam int                 IF_DW_DEFAULT    = 32;
    localparam logic [31:0]        RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } if_state_t;

    // Instructions are word aligned; any set bit in [1:0] is a bad target.
    function automatic logic is_misaligned(input logic [1:0] i_lo_bits);
        return (i_lo_bits != 2'b00);
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if
// Instruction-memory request/ack bus between the fetch stage and memory.
//   req   : fetch request (master -> slave)
//   addr  : fetch address (master -> slave)
//   ack   : read data valid this cycle (slave -> master)
//   rdata : fetched instruction word (slave -> master)
// ---------------------------------------------------------------------------
interface if_stage_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     req;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic                     ack;
    logic [DATA_WIDTH-1:0]    rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_stage_pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg
// Program counter register with load enable. The value is taken verbatim
// from i_d; any PC arithmetic happens upstream.
//   clk, rst : clock, asynchronous active-high reset (loads RESET_PC)
//   i_load   : load i_d on the next rising edge
//   i_d      : next PC value
//   o_pc     : current PC
// ---------------------------------------------------------------------------
import if_pkg::*;

module pc_reg #(
    parameter int                       ADDRESS_WIDTH = IF_AW_DEFAULT,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = RESET_PC_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_load,
    input  logic [ADDRESS_WIDTH-1:0] i_d,
    output logic [ADDRESS_WIDTH-1:0] o_pc
);

    logic [ADDRESS_WIDTH-1:0] r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_d;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction fetch stage: issues requests on the imem bus, captures returned
// words into the IF/ID register, buffers one word in a skid register when
// decode stalls, and redirects on flush.
// Optional feature: define IF_MISALIGN_TRAP_EN to trap on a misaligned PC
// update (sticky o_fetch_fault, FSM parks in FAULT until reset).
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   i_trigger       : run enable; low stops issuing new fetches
//   i_next_pc       : next PC from the PC select logic
//   o_pc            : current PC (also the fetch address)
//   imem            : instruction memory bus (master side)
//   i_stall         : decode cannot accept a new IF/ID word
//   i_flush         : redirect; drop in-flight and buffered words
//   o_if_id_valid   : IF/ID word valid
//   o_if_id_instr   : IF/ID instruction
//   o_if_id_pc      : IF/ID PC
//   o_fetch_fault   : sticky misaligned-fetch flag
//
// State  | meaning
// IDLE   | no request; waits for i_trigger
// REQ    | request outstanding at o_pc; address held until ack or flush
// HOLD   | word parked in skid because IF/ID was full and stalled
// FAULT  | misaligned target trapped; only reset leaves this state
// ---------------------------------------------------------------------------
import if_pkg::*;

module if_stage #(
    parameter int                       ADDRESS_WIDTH = IF_AW_DEFAULT,
    parameter int                       DATA_WIDTH    = IF_DW_DEFAULT,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = RESET_PC_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_trigger,
    input  logic [ADDRESS_WIDTH-1:0] i_next_pc,
    output logic [ADDRESS_WIDTH-1:0] o_pc,
    if_stage_if.master               imem,
    input  logic                     i_stall,
    input  logic                     i_flush,
    output logic                     o_if_id_valid,
    output logic [DATA_WIDTH-1:0]    o_if_id_instr,
    output logic [ADDRESS_WIDTH-1:0] o_if_id_pc,
    output logic                     o_fetch_fault
);

    if_state_t                r_state;
    logic                     r_imem_req;
    logic                     r_if_id_valid;
    logic [DATA_WIDTH-1:0]    r_if_id_instr;
    logic [ADDRESS_WIDTH-1:0] r_if_id_pc;
    logic                     r_skid_valid;
    logic [DATA_WIDTH-1:0]    r_skid_instr;
    logic [ADDRESS_WIDTH-1:0] r_skid_pc;

    logic [ADDRESS_WIDTH-1:0] w_pc;
    logic                     w_flush;
    logic                     w_ack;
    logic                     w_accept;
    logic                     w_skid_cap;
    logic                     w_pc_upd;
    logic                     w_trap;
    logic                     w_pc_load;

    always_comb begin
        // FAULT ignores flush entirely.
        w_flush    = i_flush && (r_state != ST_FAULT);
        // Acks are only meaningful while a request is outstanding; a late
        // ack after reset (FSM in IDLE) falls through here.
        w_ack      = (r_state == ST_REQ) && imem.ack && !w_flush;
        w_accept   = w_ack && (!r_if_id_valid || !i_stall);
        w_skid_cap = w_ack && r_if_id_valid && i_stall;
        w_pc_upd   = w_flush || w_ack;
`ifdef IF_MISALIGN_TRAP_EN
        w_trap     = w_pc_upd && is_misaligned(i_next_pc[1:0]);
`else
        w_trap     = 1'b0;
`endif
        w_pc_load  = w_pc_upd && !w_trap;
    end

    pc_reg #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .RESET_PC      (RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_pc_load),
        .i_d    (i_next_pc),
        .o_pc   (w_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_imem_req    <= 1'b0;
            r_if_id_valid <= 1'b0;
            r_if_id_instr <= '0;
            r_if_id_pc    <= '0;
            r_skid_valid  <= 1'b0;
            r_skid_instr  <= '0;
            r_skid_pc     <= '0;
        end else begin
            if (w_flush) begin
                r_if_id_valid <= 1'b0;
                r_skid_valid  <= 1'b0;
                r_state       <= i_trigger ? ST_REQ : ST_IDLE;
                r_imem_req    <= i_trigger;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (!i_stall) begin
                            r_if_id_valid <= 1'b0;
                        end
                        if (i_trigger) begin
                            r_state    <= ST_REQ;
                            r_imem_req <= 1'b1;
                        end
                    end
                    ST_REQ: begin
                        if (w_accept) begin
                            r_if_id_valid <= 1'b1;
                            r_if_id_instr <= imem.rdata;
                            r_if_id_pc    <= w_pc;
                            r_state       <= i_trigger ? ST_REQ : ST_IDLE;
                            r_imem_req    <= i_trigger;
                        end else if (w_skid_cap) begin
                            r_skid_valid <= 1'b1;
                            r_skid_instr <= imem.rdata;
                            r_skid_pc    <= w_pc;
                            r_state      <= ST_HOLD;
                            r_imem_req   <= 1'b0;
                        end else if (!i_stall) begin
                            r_if_id_valid <= 1'b0;
                        end
                    end
                    ST_HOLD: begin
                        if (!i_stall) begin
                            r_if_id_valid <= r_skid_valid;
                            r_if_id_instr <= r_skid_instr;
                            r_if_id_pc    <= r_skid_pc;
                            r_skid_valid  <= 1'b0;
                            r_state       <= i_trigger ? ST_REQ : ST_IDLE;
                            r_imem_req    <= i_trigger;
                        end
                    end
                    ST_FAULT: begin
                        // Decode may still drain the word it already holds.
                        if (!i_stall) begin
                            r_if_id_valid <= 1'b0;
                        end
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_imem_req <= 1'b0;
                    end
                endcase
            end
            // A trapped PC update overrides whatever the branch above chose.
            if (w_trap) begin
                r_state    <= ST_FAULT;
                r_imem_req <= 1'b0;
            end
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    logic r_fault;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (w_trap) begin
            r_fault <= 1'b1;
        end
    end

    assign o_fetch_fault = r_fault;
`else
    assign o_fetch_fault = 1'b0;
`endif

    assign o_pc          = w_pc;
    assign imem.req      = r_imem_req;
    assign imem.addr     = w_pc;
    assign o_if_id_valid = r_if_id_valid;
    assign o_if_id_instr = r_if_id_instr;
    assign o_if_id_pc    = r_if_id_pc;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    import if_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trig = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] next_pc = 32'h0;
    logic [31:0] pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        fault;

    int n_cmp = 0;
    int n_err = 0;

    if_stage_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) imem_bus ();

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .i_trigger     (trig),
        .i_next_pc     (next_pc),
        .o_pc          (pc),
        .imem          (imem_bus),
        .i_stall       (stall),
        .i_flush       (flush),
        .o_if_id_valid (id_valid),
        .o_if_id_instr (id_instr),
        .o_if_id_pc    (id_pc),
        .o_fetch_fault (fault)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory answers the current request; upstream supplies pc+4.
    task automatic ack_cur();
        imem_bus.ack   = 1'b1;
        imem_bus.rdata = memf(imem_bus.addr);
        next_pc        = pc + 32'd4;
    endtask

    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic [31:0] pc_before;
    int          n_cons;
    logic        p_req, p_ack, p_flush, p_valid, p_stall;
    logic [31:0] p_addr, p_idpc, p_instr;

    initial begin
        imem_bus.ack   = 1'b0;
        imem_bus.rdata = 32'h0;

        // Reset state
        #12;
        chk("rst_pc",       pc,                    32'h0);
        chk("rst_req",      32'(imem_bus.req),     32'h0);
        chk("rst_valid",    32'(id_valid),         32'h0);
        chk("rst_instr",    id_instr,              32'h0);
        chk("rst_idpc",     id_pc,                 32'h0);
        chk("rst_fault",    32'(fault),            32'h0);

        // First request one cycle after reset release
        tick();
        rst = 1'b0;
        trig = 1'b1;
        next_pc = pc + 32'd4;
        tick();
        chk("first_req",    32'(imem_bus.req),     32'h1);
        chk("first_addr",   imem_bus.addr,         32'h0);

        // Back-to-back fetch of 0 and 4
        for (int i = 0; i < 2; i++) begin
            ack_cur();
            tick();
            chk("seq_valid", 32'(id_valid),        32'h1);
            chk("seq_idpc",  id_pc,                32'(i * 4));
            chk("seq_instr", id_instr,             memf(32'(i * 4)));
            chk("seq_addr",  imem_bus.addr,        32'((i + 1) * 4));
        end

        // Stall while if_id holds 4; ack for 8 goes to skid
        stall = 1'b1;
        ack_cur();
        tick();
        imem_bus.ack = 1'b0;
        chk("skid_req",     32'(imem_bus.req),     32'h0);
        chk("skid_pc",      pc,                    32'hC);
        chk("skid_idpc",    id_pc,                 32'h4);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("hold_req",   32'(imem_bus.req),   32'h0);
            chk("hold_idpc",  id_pc,               32'h4);
            chk("hold_valid", 32'(id_valid),       32'h1);
        end
        stall = 1'b0;
        tick();
        chk("unskid_idpc",  id_pc,                 32'h8);
        chk("unskid_instr", id_instr,              memf(32'h8));
        chk("unskid_valid", 32'(id_valid),         32'h1);
        chk("unskid_req",   32'(imem_bus.req),     32'h1);
        chk("unskid_addr",  imem_bus.addr,         32'hC);

        // Flush to 0x100 with the ack for 0xC arriving the same cycle
        flush = 1'b1;
        next_pc = 32'h100;
        imem_bus.ack = 1'b1;
        imem_bus.rdata = memf(32'hC);
        tick();
        flush = 1'b0;
        imem_bus.ack = 1'b0;
        chk("flush_valid",  32'(id_valid),         32'h0);
        chk("flush_addr",   imem_bus.addr,         32'h100);
        chk("flush_req",    32'(imem_bus.req),     32'h1);
        ack_cur();
        tick();
        imem_bus.ack = 1'b0;
        chk("redir_idpc",   id_pc,                 32'h100);
        chk("redir_instr",  id_instr,              memf(32'h100));

        // Reset pulsed mid-request at 0x10
        flush = 1'b1;
        next_pc = 32'h10;
        tick();
        flush = 1'b0;
        chk("pre_rst_addr", imem_bus.addr,         32'h10);
        #2 rst = 1'b1;
        #1;
        chk("arst_pc",      pc,                    32'h0);
        chk("arst_valid",   32'(id_valid),         32'h0);
        chk("arst_req",     32'(imem_bus.req),     32'h0);
        #1 rst = 1'b0;
        imem_bus.ack = 1'b1;
        imem_bus.rdata = 32'hDEAD_BEEF;
        next_pc = 32'h14;
        tick();
        imem_bus.ack = 1'b0;
        chk("stray_valid",  32'(id_valid),         32'h0);
        chk("stray_pc",     pc,                    32'h0);
        chk("refetch_req",  32'(imem_bus.req),     32'h1);
        ack_cur();
        tick();
        imem_bus.ack = 1'b0;
        chk("refetch_idpc", id_pc,                 32'h0);
        chk("refetch_ins",  id_instr,              memf(32'h0));

        // Trigger dropped with a request outstanding
        trig = 1'b0;
        tick();
        chk("trigoff_req",  32'(imem_bus.req),     32'h1);
        chk("trigoff_addr", imem_bus.addr,         32'h4);
        ack_cur();
        tick();
        imem_bus.ack = 1'b0;
        chk("trigoff_idpc", id_pc,                 32'h4);
        chk("trigoff_done", 32'(imem_bus.req),     32'h0);
        tick();
        tick();
        chk("idle_req",     32'(imem_bus.req),     32'h0);
        chk("idle_valid",   32'(id_valid),         32'h0);

        // Randomized run against a stream model: decode must see an
        // unbroken pc, pc+4, ... sequence restarting at each flush target.
        rst = 1'b1;
        #2 rst = 1'b0;
        trig = 1'b1;
        exp_pc = 32'h0;
        n_cons = 0;
        p_req = 1'b0; p_ack = 1'b0; p_flush = 1'b0; p_valid = 1'b0; p_stall = 1'b0;
        p_addr = 32'h0; p_idpc = 32'h0; p_instr = 32'h0;
        for (int c = 0; c < 600; c++) begin
            if (p_req && !p_ack && !p_flush) begin
                chk("addr_stable", imem_bus.addr,      p_addr);
                chk("req_held",    32'(imem_bus.req),  32'h1);
            end
            if (p_valid && p_stall && !p_flush) begin
                chk("stall_valid", 32'(id_valid),      32'h1);
                chk("stall_idpc",  id_pc,              p_idpc);
                chk("stall_instr", id_instr,           p_instr);
            end
            stall = ($urandom % 3) == 0;
            flush = ($urandom % 16) == 0;
            trig  = ($urandom % 12) != 0;
            imem_bus.ack = imem_bus.req && (($urandom % 2) == 0);
            imem_bus.rdata = imem_bus.ack ? memf(imem_bus.addr) : $urandom;
            tgt = 32'($urandom_range(32'h40, 32'h3FF)) << 2;
            next_pc = flush ? tgt : pc + 32'd4;
            if (flush) begin
                exp_pc = tgt;
            end else if (id_valid && !stall) begin
                chk("stream_pc",    id_pc,    exp_pc);
                chk("stream_instr", id_instr, memf(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_cons++;
            end
            p_req = imem_bus.req; p_ack = imem_bus.ack; p_flush = flush;
            p_valid = id_valid; p_stall = stall;
            p_addr = imem_bus.addr; p_idpc = id_pc; p_instr = id_instr;
            tick();
        end
        chk("stream_count", 32'(n_cons > 30),      32'h1);
        chk("rand_fault",   32'(fault),            32'h0);

        // Misaligned redirect target
        stall = 1'b0; flush = 1'b0; imem_bus.ack = 1'b0; trig = 1'b0;
        tick();
        tick();
        pc_before = pc;
        flush = 1'b1;
        next_pc = 32'h102;
        tick();
        flush = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        chk("trap_fault",   32'(fault),            32'h1);
        chk("trap_pc",      pc,                    pc_before);
        chk("trap_req",     32'(imem_bus.req),     32'h0);
        trig = 1'b1;
        tick();
        tick();
        chk("fault_req",    32'(imem_bus.req),     32'h0);
        flush = 1'b1;
        next_pc = 32'h200;
        tick();
        flush = 1'b0;
        chk("fault_noflush", pc,                   pc_before);
        chk("fault_sticky", 32'(fault),            32'h1);
`else
        chk("misal_pc",     pc,                    32'h102);
        chk("misal_fault",  32'(fault),            32'h0);
        chk("misal_req",    32'(imem_bus.req),     32'h0);
        trig = 1'b1;
        tick();
        chk("misal_fetch",  32'(imem_bus.req),     32'h1);
        chk("misal_addr",   imem_bus.addr,         32'h102);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 ADDRESS_WIDTH, 32, PC and instruction-memory address width.
REQ-002 DATA_WIDTH, 32, instruction word width.
REQ-003 RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 trigger  input  1  run enable; low = stop issuing new fetches.
REQ-007 next_pc  input  ADDRESS_WIDTH  next PC computed by the PC select logic from pc.
REQ-008 pc  output  ADDRESS_WIDTH  current PC, fed back to the PC select logic.
REQ-009 imem_req  output  1  fetch request to instruction memory.
REQ-010 imem_addr  output  ADDRESS_WIDTH  fetch address, always equal to pc.
REQ-011 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-012 imem_rdata  input  DATA_WIDTH  fetched instruction.
REQ-013 stall  input  1  decode cannot accept a new if_id word.
REQ-014 flush  input  1  redirect; discard in-flight and buffered instructions.
REQ-015 if_id_valid / if_id_instr / if_id_pc  output  1 / DATA_WIDTH / ADDRESS_WIDTH  IF/ID pipeline register.
REQ-016 fetch_fault  output  1  sticky misaligned-fetch flag.

Function
REQ-017 FSM states SHALL be IDLE, REQ, HOLD, FAULT.
REQ-018 IDLE: imem_req=0; trigger=1 -> REQ next cycle.
REQ-019 REQ: imem_req=1; imem_addr SHALL stay stable until imem_ack.
REQ-020 An ack SHALL be accepted when flush=0 and (if_id_valid=0 or stall=0).
- if_id <= {1, imem_rdata, pc} and pc <= next_pc, same edge.
REQ-021 After an accepted ack, the FSM SHALL stay in REQ if trigger=1, else go to IDLE.
- Fetch latency: request to if_id_valid is one cycle after ack.
REQ-022 Ack with stall=1 and if_id_valid=1:
- word and pc go to the skid register; pc <= next_pc; FSM -> HOLD.
- imem_req=0 in HOLD.
REQ-023 HOLD with stall=0: skid moves to if_id; FSM -> REQ if trigger, else IDLE.
REQ-024 stall=1 with if_id_valid=1: if_id SHALL hold unchanged.
REQ-025 stall=0 with no accepted ack: if_id_valid <= 0.
REQ-026 flush=1 in any state except FAULT:
- if_id_valid <= 0; skid discarded; any ack that cycle discarded.
- pc <= next_pc; FSM -> REQ if trigger, else IDLE.
- An outstanding request is not retracted; imem_addr changes only after ack or flush.
REQ-027 flush and stall together: flush SHALL win.
REQ-028 trigger falling in REQ before ack: request SHALL still complete; FSM -> IDLE after ack.
REQ-029 PC arithmetic is done upstream; this block SHALL only register next_pc without modifying it.

Reset
REQ-030 On rst=1 (asynchronous): pc=RESET_PC, FSM=IDLE, imem_req=0, if_id_valid=0, if_id_instr=0, if_id_pc=0, skid empty, fetch_fault=0.
REQ-031 Reset mid-request SHALL abandon the request; a late ack SHALL be ignored while FSM is IDLE.
REQ-032 First request SHALL issue one cycle after rst deasserts with trigger=1.

Configuration
REQ-033 Macro IF_MISALIGN_TRAP_EN, when defined:
- pc update with next_pc[1:0]!=0 SHALL set fetch_fault=1 and move FSM to FAULT; pc is not updated.
- FAULT: imem_req=0; flush is ignored; exit only by reset.
REQ-034 When IF_MISALIGN_TRAP_EN is undefined: fetch_fault tied 0, FAULT state unreachable, next_pc loaded as-is.

Structure
REQ-035 Shared package if_pkg SHALL hold the FSM state enum (if_state_t) and the RESET_PC default constant.
REQ-036 PC register SHALL be sub-module pc_reg (async reset, load enable, RESET_PC parameter).
- FSM, skid register and IF/ID register stay in if_stage.

Verification
REQ-037 Reset, trigger=1, ack every cycle, next_pc=pc+4 -> imem_addr 0,4,8,...; if_id_pc 0,4,8 with matching instrs.
REQ-038 stall=1 for 3 cycles while if_id holds pc=4, ack for pc=8:
- pc=8 captured in skid; imem_req=0.
- if_id_pc=8 appears the cycle after stall drops; nothing lost or duplicated.
REQ-039 flush with next_pc=0x100 while a request to 0xC is outstanding:
- ack for 0xC discarded; if_id_valid=0; next request addr=0x100.
REQ-040 rst pulsed mid-request at addr 0x10:
- pc=RESET_PC, if_id_valid=0 immediately (asynchronous).
- Stray ack ignored; refetch from RESET_PC.
REQ-041 With IF_MISALIGN_TRAP_EN defined, next_pc=0x102:
- fetch_fault=1, imem_req=0 thereafter, pc held.
- Without the macro: pc=0x102.
REQ-042 trigger dropped with request outstanding -> ack completes the fetch, FSM IDLE, no further imem_req.
